ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline; consumes ID/EX register outputs.
//  Resolves RAW hazards by forwarding from EX/MEM (own outputs) and MEM/WB, runs the ALU, computes branch target/zero.
//  Registers results for the MEM stage; optional iterative multiplier stalls upstream while busy.
// PARAMETERS
//  DATA_W   32   datapath width
//  REG_AW   5    register-index width
//  MUL_CYC  32   multiplier iterations (one bit per cycle, MUL_CYC == DATA_W)
// PORTS
//  clk                   in   1       single clock, all state on posedge
//  rst                   in   1       synchronous, active-high reset
//  EX_regdst/alusrc/memtoreg/regwrite/memread/memwrite/branch  in 1 each  control from ID/EX
//  EX_aluop              in   2       00 add, 01 sub, 10 funct-decoded, 11 add
//  EX_PC                 in   DATA_W  PC+4 of instruction
//  EX_Rs, EX_Rt, EX_Rd   in   REG_AW  register indices
//  EX_readda1/readda2    in   DATA_W  register-file read data
//  EX_byte_offset_or_imm in   DATA_W  sign-extended immediate; [5:0] = funct
//  EX_flush              in   1       squash instruction in EX (taken branch)
//  WB_regwrite           in   1       MEM/WB write enable
//  WB_Rd                 in   REG_AW  MEM/WB destination
//  WB_writedata          in   DATA_W  MEM/WB result
//  EX_stall              out  1       upstream (PC, IF/ID, ID/EX) must hold while 1
//  MEM_memtoreg/regwrite/memread/memwrite/branch  out 1 each  registered controls
//  MEM_zero              out  1       registered ALU result == 0
//  MEM_branch_target     out  DATA_W  registered EX_PC + (imm << 2)
//  MEM_aluresult         out  DATA_W  registered ALU/multiplier result
//  MEM_writedata         out  DATA_W  registered forwarded Rt data (store data)
//  MEM_Rd                out  REG_AW  registered destination (regdst ? Rd : Rt)
// BEHAVIOUR
//  - Reset: every MEM_* output 0, EX_stall 0, FSM IDLE, counter 0.
//  - Forward A: MEM_regwrite && MEM_Rd!=0 && MEM_Rd==EX_Rs -> MEM_aluresult; else WB_regwrite && WB_Rd!=0
//    && WB_Rd==EX_Rs -> WB_writedata; else EX_readda1. Forward B identical with EX_Rt / EX_readda2. EX/MEM wins.
//  - ALU B = alusrc ? imm : fwdB. Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, other -> 0.
//  - Add/sub wrap modulo 2^DATA_W, no overflow trap. MEM_zero from ALU result.
//  - Latency 1: non-stalled instruction presented in cycle n appears on MEM_* after edge n.
//  - EX_flush=1: next EX/MEM controls (memtoreg, regwrite, memread, memwrite, branch) load 0; data fields load normally.
//  - While EX_stall=1: EX/MEM loads bubble (all controls 0); upstream holds EX_* stable.
//  - rst has priority over flush, flush over stall.
// CONFIGURATION
//  MULDIV_EN defined: funct 0x18 with aluop 10 = unsigned multiply, low DATA_W bits to MEM_aluresult.
//   FSM IDLE -> BUSY on detect (EX_stall asserted combinationally same cycle); BUSY runs MUL_CYC shift-add
//   cycles, counter 0..MUL_CYC-1; -> DONE: EX_stall=0, EX/MEM captures product with instruction controls; DONE -> IDLE.
//   Total: EX_stall high MUL_CYC+1 cycles, result on MEM_* one edge after DONE.
//   EX_flush in BUSY/DONE: abort to IDLE, stall drops next cycle, no result written. rst mid-op: IDLE, outputs 0.
//  MULDIV_EN undefined: no FSM; funct 0x18 yields 0 like any unknown funct; EX_stall tied 0.
// STRUCTURE
//  Shared package: aluop encodings, funct constants (ADD/SUB/AND/OR/SLT/MULT), mult FSM state typedef.
//  One sub-module: ex_mul_iter (shift-add multiplier + counter FSM), instantiated only under MULDIV_EN.
//  Forwarding muxes, ALU, branch adder and EX/MEM register stay in this module.
// TESTING
//  1 add $3,$1,$2 with readda1=5, readda2=7, no hazards -> MEM_aluresult=12, MEM_Rd=3, MEM_regwrite=1.
//  2 Back-to-back: MEM_Rd=3 result 12, WB_Rd=3 data 99, next EX_Rs=3 -> uses 12 (EX/MEM priority); Rs=0 never forwarded.
//  3 beq, PC=0x100, imm=4, equal operands, aluop 01 -> MEM_zero=1, MEM_branch_target=0x110, MEM_branch=1.
//  4 EX_flush=1 with sw -> MEM_memwrite=0, MEM_regwrite=0 next cycle; rst with live data -> all MEM_* 0.
//  5 MULDIV_EN: 0x0001_0000 * 0x0003_0000 -> EX_stall high 33 cycles, MEM_aluresult=0 (low word), controls bubbled meanwhile.
//  6 MULDIV_EN: 6*7, EX_flush at BUSY cycle 10 -> stall drops, no regwrite; slt -1<1 -> MEM_aluresult=1.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, R-type funct values,
// multiplier FSM states and the bundle of control bits carried into MEM.
package ex_mem_stage_pkg;

   localparam logic [1:0] ALUOP_ADD     = 2'b00;
   localparam logic [1:0] ALUOP_SUB     = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
   localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MULT = 6'h18;

   typedef logic [1:0] mul_state_t;
   localparam mul_state_t MUL_IDLE = 2'd0;
   localparam mul_state_t MUL_BUSY = 2'd1;
   localparam mul_state_t MUL_DONE = 2'd2;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
      logic memread;
      logic memwrite;
      logic branch;
   } mem_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM boundary bundle; the master side feeds the stage, the
// slave side is the execute stage itself.
interface ex_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);

   logic              EX_regdst;
   logic              EX_alusrc;
   logic              EX_memtoreg;
   logic              EX_regwrite;
   logic              EX_memread;
   logic              EX_memwrite;
   logic              EX_branch;
   logic [1:0]        EX_aluop;
   logic [DATA_W-1:0] EX_PC;
   logic [REG_AW-1:0] EX_Rs;
   logic [REG_AW-1:0] EX_Rt;
   logic [REG_AW-1:0] EX_Rd;
   logic [DATA_W-1:0] EX_readda1;
   logic [DATA_W-1:0] EX_readda2;
   logic [DATA_W-1:0] EX_byte_offset_or_imm;
   logic              EX_flush;
   logic              WB_regwrite;
   logic [REG_AW-1:0] WB_Rd;
   logic [DATA_W-1:0] WB_writedata;

   logic              EX_stall;
   logic              MEM_memtoreg;
   logic              MEM_regwrite;
   logic              MEM_memread;
   logic              MEM_memwrite;
   logic              MEM_branch;
   logic              MEM_zero;
   logic [DATA_W-1:0] MEM_branch_target;
   logic [DATA_W-1:0] MEM_aluresult;
   logic [DATA_W-1:0] MEM_writedata;
   logic [REG_AW-1:0] MEM_Rd;

   modport master (
      output EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite, EX_memread,
             EX_memwrite, EX_branch, EX_aluop, EX_PC, EX_Rs, EX_Rt, EX_Rd,
             EX_readda1, EX_readda2, EX_byte_offset_or_imm, EX_flush,
             WB_regwrite, WB_Rd, WB_writedata,
      input  EX_stall, MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite,
             MEM_branch, MEM_zero, MEM_branch_target, MEM_aluresult,
             MEM_writedata, MEM_Rd
   );

   modport slave (
      input  EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite, EX_memread,
             EX_memwrite, EX_branch, EX_aluop, EX_PC, EX_Rs, EX_Rt, EX_Rd,
             EX_readda1, EX_readda2, EX_byte_offset_or_imm, EX_flush,
             WB_regwrite, WB_Rd, WB_writedata,
      output EX_stall, MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite,
             MEM_branch, MEM_zero, MEM_branch_target, MEM_aluresult,
             MEM_writedata, MEM_Rd
   );

endinterface

// File: rtl/ex_mem_stage_mul_iter.sv
// Iterative shift-add multiplier (one multiplier bit per cycle) with its
// IDLE/BUSY/DONE sequencer; only built when MULDIV_EN is defined.
`ifdef MULDIV_EN
module ex_mul_iter
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_CYC = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_req,
   input  logic              abort,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              stall,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

   mul_state_t        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [DATA_W-1:0] mcand_q,  mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] prod_q,   prod_d;

   // Stall is raised in the detect cycle itself so upstream freezes at once.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      stall    = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (start_req) begin
               stall    = 1'b1;
               state_d  = MUL_BUSY;
               cnt_d    = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               prod_d   = '0;
            end
         end
         MUL_BUSY: begin
            stall    = 1'b1;
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MUL_CYC - 1)) begin
               state_d = MUL_DONE;
               cnt_d   = '0;
            end
            if (abort) begin
               state_d = MUL_IDLE;
               cnt_d   = '0;
            end
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   assign product = prod_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

endmodule
`endif

// File: rtl/ex_mem_stage.sv
// MIPS execute stage plus EX/MEM register: forwarding, ALU, branch target.
// Define MULDIV_EN to add the iterative unsigned multiply (funct 0x18).
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5
`ifdef MULDIV_EN
   ,
   parameter int MUL_CYC = DATA_W
`endif
) (
   input  logic          clk,
   input  logic          rst,
   ex_mem_stage_if.slave bus
);

   mem_ctrl_t         mem_ctrl_q,          mem_ctrl_d;
   logic              mem_zero_q,          mem_zero_d;
   logic [DATA_W-1:0] mem_branch_target_q, mem_branch_target_d;
   logic [DATA_W-1:0] mem_aluresult_q,     mem_aluresult_d;
   logic [DATA_W-1:0] mem_writedata_q,     mem_writedata_d;
   logic [REG_AW-1:0] mem_rd_q,            mem_rd_d;

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic [5:0]        funct;
   logic              ex_stall;
   logic              ctrl_kill;

   // EX/MEM is the younger producer, so it is checked before MEM/WB.
   always_comb begin
      fwd_a = bus.EX_readda1;
      if (mem_ctrl_q.regwrite && (mem_rd_q != '0) && (mem_rd_q == bus.EX_Rs)) begin
         fwd_a = mem_aluresult_q;
      end else if (bus.WB_regwrite && (bus.WB_Rd != '0) && (bus.WB_Rd == bus.EX_Rs)) begin
         fwd_a = bus.WB_writedata;
      end
      fwd_b = bus.EX_readda2;
      if (mem_ctrl_q.regwrite && (mem_rd_q != '0) && (mem_rd_q == bus.EX_Rt)) begin
         fwd_b = mem_aluresult_q;
      end else if (bus.WB_regwrite && (bus.WB_Rd != '0) && (bus.WB_Rd == bus.EX_Rt)) begin
         fwd_b = bus.WB_writedata;
      end
   end

   assign alu_b = bus.EX_alusrc ? bus.EX_byte_offset_or_imm : fwd_b;
   assign funct = bus.EX_byte_offset_or_imm[5:0];

`ifdef MULDIV_EN
   logic              mul_req;
   logic [DATA_W-1:0] mul_product;

   // A flushed multiply is squashed, so it must never start the sequencer.
   assign mul_req = (bus.EX_aluop == ALUOP_FUNCT) && (funct == FUNCT_MULT) && !bus.EX_flush;

   ex_mul_iter #(
      .DATA_W  (DATA_W),
      .MUL_CYC (MUL_CYC)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_req (mul_req),
      .abort     (bus.EX_flush),
      .op_a      (fwd_a),
      .op_b      (alu_b),
      .stall     (ex_stall),
      .product   (mul_product)
   );
`else
   assign ex_stall = 1'b0;
`endif

   always_comb begin
      alu_result = '0;
      case (bus.EX_aluop)
         ALUOP_SUB: alu_result = fwd_a - alu_b;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD:  alu_result = fwd_a + alu_b;
               FUNCT_SUB:  alu_result = fwd_a - alu_b;
               FUNCT_AND:  alu_result = fwd_a & alu_b;
               FUNCT_OR:   alu_result = fwd_a | alu_b;
               FUNCT_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
`ifdef MULDIV_EN
               FUNCT_MULT: alu_result = mul_product;
`endif
               default:    alu_result = '0;
            endcase
         end
         default: alu_result = fwd_a + alu_b;
      endcase
   end

   // Flush and stall only bubble the controls; data fields always load.
   always_comb begin
      ctrl_kill           = bus.EX_flush || ex_stall;
      mem_ctrl_d          = '0;
      if (!ctrl_kill) begin
         mem_ctrl_d.memtoreg = bus.EX_memtoreg;
         mem_ctrl_d.regwrite = bus.EX_regwrite;
         mem_ctrl_d.memread  = bus.EX_memread;
         mem_ctrl_d.memwrite = bus.EX_memwrite;
         mem_ctrl_d.branch   = bus.EX_branch;
      end
      mem_zero_d          = (alu_result == '0);
      mem_branch_target_d = bus.EX_PC + (bus.EX_byte_offset_or_imm << 2);
      mem_aluresult_d     = alu_result;
      mem_writedata_d     = fwd_b;
      mem_rd_d            = bus.EX_regdst ? bus.EX_Rd : bus.EX_Rt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ctrl_q          <= '0;
         mem_zero_q          <= 1'b0;
         mem_branch_target_q <= '0;
         mem_aluresult_q     <= '0;
         mem_writedata_q     <= '0;
         mem_rd_q            <= '0;
      end else begin
         mem_ctrl_q          <= mem_ctrl_d;
         mem_zero_q          <= mem_zero_d;
         mem_branch_target_q <= mem_branch_target_d;
         mem_aluresult_q     <= mem_aluresult_d;
         mem_writedata_q     <= mem_writedata_d;
         mem_rd_q            <= mem_rd_d;
      end
   end

   assign bus.EX_stall          = ex_stall;
   assign bus.MEM_memtoreg      = mem_ctrl_q.memtoreg;
   assign bus.MEM_regwrite      = mem_ctrl_q.regwrite;
   assign bus.MEM_memread       = mem_ctrl_q.memread;
   assign bus.MEM_memwrite      = mem_ctrl_q.memwrite;
   assign bus.MEM_branch        = mem_ctrl_q.branch;
   assign bus.MEM_zero          = mem_zero_q;
   assign bus.MEM_branch_target = mem_branch_target_q;
   assign bus.MEM_aluresult     = mem_aluresult_q;
   assign bus.MEM_writedata     = mem_writedata_q;
   assign bus.MEM_Rd            = mem_rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random instructions checked
// against a spec-level model; multiply scenarios follow MULDIV_EN.
module tb_ex_mem_stage;

   localparam logic [6:0] C_NONE  = 7'b000_0000;
   localparam logic [6:0] C_RTYPE = 7'b100_1000;
   localparam logic [6:0] C_SW    = 7'b010_0010;
   localparam logic [6:0] C_BEQ   = 7'b000_0001;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic        m_regwrite;
   logic [4:0]  m_rd;
   logic [31:0] m_result;

   logic [4:0]  e_ctrl;
   logic        e_zero;
   logic [4:0]  e_rd;
   logic [31:0] e_result;
   logic [31:0] e_target;
   logic [31:0] e_wdata;

   ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic [6:0] ctrl, input logic [1:0] op,
                                 input logic [31:0] pc, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic flush);
      {bus.EX_regdst, bus.EX_alusrc, bus.EX_memtoreg, bus.EX_regwrite,
       bus.EX_memread, bus.EX_memwrite, bus.EX_branch} = ctrl;
      bus.EX_aluop = op;
      bus.EX_PC = pc;
      bus.EX_Rs = rs;
      bus.EX_Rt = rt;
      bus.EX_Rd = rd;
      bus.EX_readda1 = d1;
      bus.EX_readda2 = d2;
      bus.EX_byte_offset_or_imm = imm;
      bus.EX_flush = flush;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      bus.WB_regwrite = we;
      bus.WB_Rd = rd;
      bus.WB_writedata = data;
   endtask

   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (op == 2'b01) return a - b;
      if (op != 2'b10) return a + b;
      case (fn)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
`ifdef MULDIV_EN
         6'h18: return a * b;
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
      if (m_regwrite && m_rd != 0 && m_rd == idx) return m_result;
      if (bus.WB_regwrite && bus.WB_Rd != 0 && bus.WB_Rd == idx) return bus.WB_writedata;
      return rf;
   endfunction

   task automatic predict();
      logic [31:0] fa;
      logic [31:0] fb;
      fa = ref_fwd(bus.EX_Rs, bus.EX_readda1);
      fb = ref_fwd(bus.EX_Rt, bus.EX_readda2);
      e_result = ref_alu(bus.EX_aluop, bus.EX_byte_offset_or_imm[5:0], fa,
                         bus.EX_alusrc ? bus.EX_byte_offset_or_imm : fb);
      e_zero   = (e_result == 32'd0);
      e_target = bus.EX_PC + bus.EX_byte_offset_or_imm * 32'd4;
      e_wdata  = fb;
      e_rd     = bus.EX_regdst ? bus.EX_Rd : bus.EX_Rt;
      e_ctrl   = bus.EX_flush ? 5'b0 : {bus.EX_memtoreg, bus.EX_regwrite,
                                        bus.EX_memread, bus.EX_memwrite, bus.EX_branch};
   endtask

   task automatic commit();
      m_regwrite = e_ctrl[3];
      m_rd = e_rd;
      m_result = e_result;
   endtask

   task automatic test_reset();
      logic [106:0] obs;
      rst = 1'b1;
      set_wb(1'b1, 5'd3, 32'hDEAD_BEEF);
      apply_stimulus(C_RTYPE | C_SW, 2'b10, 32'h40, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'h20, 1'b0);
      @(posedge clk); #1;
      obs = {bus.MEM_memtoreg, bus.MEM_regwrite, bus.MEM_memread, bus.MEM_memwrite, bus.MEM_branch,
             bus.MEM_zero, bus.MEM_Rd, bus.MEM_aluresult, bus.MEM_branch_target, bus.MEM_writedata};
      checks++;
      if (obs !== 107'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 0", obs);
      end
      checks++;
      if (bus.EX_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_stall: got %b want 0", bus.EX_stall);
      end
      rst = 1'b0;
      m_regwrite = 1'b0;
      m_rd = 5'd0;
      m_result = 32'd0;
   endtask

   task automatic test_add();
      set_wb(1'b0, 5'd0, 32'd0);
      apply_stimulus(C_RTYPE, 2'b10, 32'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20, 1'b0);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_aluresult !== 32'd12) begin
         errors++;
         $display("[TB] FAIL add_result: got %0d want 12", bus.MEM_aluresult);
      end
      checks++;
      if (bus.MEM_Rd !== 5'd3) begin
         errors++;
         $display("[TB] FAIL add_rd: got %0d want 3", bus.MEM_Rd);
      end
      checks++;
      if (bus.MEM_regwrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_regwrite: got %b want 1", bus.MEM_regwrite);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [4];
      want = '{32'd12, 32'd99, 32'd77, 32'd0};
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin
               set_wb(1'b1, 5'd3, 32'd99);
               apply_stimulus(C_RTYPE, 2'b10, 32'h4, 5'd3, 5'd0, 5'd4, 32'd0, 32'd0, 32'h20, 1'b0);
            end
            1: apply_stimulus(C_RTYPE, 2'b10, 32'h8, 5'd3, 5'd0, 5'd5, 32'd0, 32'd0, 32'h20, 1'b0);
            2: apply_stimulus(C_RTYPE, 2'b10, 32'hC, 5'd9, 5'd9, 5'd0, 32'd77, 32'd0, 32'h20, 1'b0);
            default: begin
               set_wb(1'b1, 5'd0, 32'd55);
               apply_stimulus(C_RTYPE, 2'b10, 32'h10, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'h20, 1'b0);
            end
         endcase
         predict();
         @(posedge clk); #1;
         commit();
         checks++;
         if (bus.MEM_aluresult !== want[k]) begin
            errors++;
            $display("[TB] FAIL fwd_step%0d: got %0d want %0d", k, bus.MEM_aluresult, want[k]);
         end
      end
   endtask

   task automatic test_branch();
      set_wb(1'b0, 5'd0, 32'd0);
      apply_stimulus(C_BEQ, 2'b01, 32'h100, 5'd7, 5'd7, 5'd0, 32'h1234, 32'h1234, 32'd4, 1'b0);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_zero !== 1'b1 || bus.MEM_branch !== 1'b1) begin
         errors++;
         $display("[TB] FAIL beq_zero_branch: got %b%b want 11", bus.MEM_zero, bus.MEM_branch);
      end
      checks++;
      if (bus.MEM_branch_target !== 32'h110) begin
         errors++;
         $display("[TB] FAIL beq_target: got %h want 00000110", bus.MEM_branch_target);
      end
   endtask

   task automatic test_flush_reset();
      logic [106:0] obs;
      apply_stimulus(C_SW, 2'b00, 32'h20, 5'd8, 5'd9, 5'd0, 32'h1000, 32'hABCD, 32'd8, 1'b1);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_memwrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_memwrite: got %b want 0", bus.MEM_memwrite);
      end
      checks++;
      if (bus.MEM_aluresult !== 32'h1008 || bus.MEM_writedata !== 32'hABCD) begin
         errors++;
         $display("[TB] FAIL flush_data: got %h/%h want 00001008/0000abcd",
                  bus.MEM_aluresult, bus.MEM_writedata);
      end
      apply_stimulus(C_RTYPE, 2'b10, 32'h24, 5'd8, 5'd9, 5'd10, 32'd1, 32'd2, 32'h20, 1'b1);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_regwrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_regwrite: got %b want 0", bus.MEM_regwrite);
      end
      rst = 1'b1;
      apply_stimulus(C_RTYPE | C_BEQ, 2'b10, 32'h28, 5'd1, 5'd2, 5'd11, 32'd3, 32'd3, 32'h22, 1'b0);
      @(posedge clk); #1;
      obs = {bus.MEM_memtoreg, bus.MEM_regwrite, bus.MEM_memread, bus.MEM_memwrite, bus.MEM_branch,
             bus.MEM_zero, bus.MEM_Rd, bus.MEM_aluresult, bus.MEM_branch_target, bus.MEM_writedata};
      checks++;
      if (obs !== 107'd0) begin
         errors++;
         $display("[TB] FAIL live_reset: got %h want 0", obs);
      end
      rst = 1'b0;
      m_regwrite = 1'b0;
      m_rd = 5'd0;
      m_result = 32'd0;
   endtask

   task automatic test_random();
      logic [5:0]   fset [7];
      logic [5:0]   fn;
      logic [31:0]  r;
      logic [31:0]  d1;
      logic [31:0]  d2;
      logic [106:0] obs;
      logic [106:0] exp;
`ifdef MULDIV_EN
      fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h3F};
`else
      fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h3F};
`endif
      for (int i = 0; i < 300; i++) begin
         fn = fset[$urandom_range(0, 6)];
         r  = $urandom;
         d1 = $urandom;
         d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         apply_stimulus(7'($urandom), 2'($urandom), $urandom, 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), d1, d2,
                        {r[31:6], fn}, ($urandom_range(0, 7) == 0));
         #1;
         checks++;
         if (bus.EX_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_stall #%0d: got %b want 0", i, bus.EX_stall);
         end
         predict();
         @(posedge clk); #1;
         commit();
         obs = {bus.MEM_memtoreg, bus.MEM_regwrite, bus.MEM_memread, bus.MEM_memwrite, bus.MEM_branch,
                bus.MEM_zero, bus.MEM_Rd, bus.MEM_aluresult, bus.MEM_branch_target, bus.MEM_writedata};
         exp = {e_ctrl, e_zero, e_rd, e_result, e_target, e_wdata};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL rand_mem #%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_slt();
      set_wb(1'b0, 5'd0, 32'd0);
      apply_stimulus(C_RTYPE, 2'b10, 32'h30, 5'd20, 5'd21, 5'd22, 32'hFFFF_FFFF, 32'd1, 32'h2A, 1'b0);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_aluresult !== 32'd1) begin
         errors++;
         $display("[TB] FAIL slt_neg_lt_pos: got %0d want 1", bus.MEM_aluresult);
      end
      apply_stimulus(C_RTYPE, 2'b10, 32'h34, 5'd20, 5'd21, 5'd23, 32'd1, 32'hFFFF_FFFF, 32'h2A, 1'b0);
      predict();
      @(posedge clk); #1;
      commit();
      checks++;
      if (bus.MEM_aluresult !== 32'd0 || bus.MEM_zero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL slt_pos_lt_neg: got %0d zero %b want 0 zero 1",
                  bus.MEM_aluresult, bus.MEM_zero);
      end
   endtask

`ifdef MULDIV_EN
   task automatic test_mult();
      logic [31:0] ma [2];
      logic [31:0] mb [2];
      logic [31:0] want;
      int          ncyc;
      bit          done_ok;
      ma[0] = 32'h0001_0000;
      mb[0] = 32'h0003_0000;
      ma[1] = $urandom;
      mb[1] = $urandom;
      set_wb(1'b0, 5'd0, 32'd0);
      for (int k = 0; k < 2; k++) begin
         want = ma[k] * mb[k];
         apply_stimulus(C_RTYPE, 2'b10, 32'h40, 5'd10, 5'd11, 5'd12, ma[k], mb[k], 32'h18, 1'b0);
         #1;
         ncyc = 0;
         done_ok = 1'b0;
         for (int c = 0; c < 40; c++) begin
            if (!bus.EX_stall) begin
               done_ok = 1'b1;
               break;
            end
            ncyc++;
            @(posedge clk); #1;
            checks++;
            if (bus.MEM_regwrite !== 1'b0) begin
               errors++;
               $display("[TB] FAIL mul_bubble: got regwrite %b want 0 at stall cycle %0d",
                        bus.MEM_regwrite, ncyc);
            end
         end
         checks++;
         if (!done_ok || ncyc != 33) begin
            errors++;
            $display("[TB] FAIL mul_stall_len: got %0d cycles (done %b) want 33", ncyc, done_ok);
         end
         @(posedge clk); #1;
         checks++;
         if (bus.MEM_aluresult !== want || bus.MEM_regwrite !== 1'b1 || bus.MEM_Rd !== 5'd12) begin
            errors++;
            $display("[TB] FAIL mul_result: got %h rw %b rd %0d want %h rw 1 rd 12",
                     bus.MEM_aluresult, bus.MEM_regwrite, bus.MEM_Rd, want);
         end
         apply_stimulus(C_NONE, 2'b00, 32'h44, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
         @(posedge clk); #1;
      end
      // Flush the multiply part-way through the BUSY phase.
      apply_stimulus(C_RTYPE, 2'b10, 32'h50, 5'd10, 5'd11, 5'd13, 32'd6, 32'd7, 32'h18, 1'b0);
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
      end
      bus.EX_flush = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(C_NONE, 2'b00, 32'h54, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      #1;
      checks++;
      if (bus.EX_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mul_abort_stall: got %b want 0", bus.EX_stall);
      end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.MEM_regwrite !== 1'b0 || bus.EX_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_abort_write: got rw %b stall %b want 0 0 at cycle %0d",
                     bus.MEM_regwrite, bus.EX_stall, c);
         end
      end
      // Reset part-way through an operation.
      apply_stimulus(C_RTYPE, 2'b10, 32'h60, 5'd10, 5'd11, 5'd14, 32'd6, 32'd7, 32'h18, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(C_NONE, 2'b00, 32'h64, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      #1;
      checks++;
      if (bus.EX_stall !== 1'b0 || bus.MEM_regwrite !== 1'b0 || bus.MEM_aluresult !== 32'd0) begin
         errors++;
         $display("[TB] FAIL mul_reset: got stall %b rw %b res %h want 0 0 0",
                  bus.EX_stall, bus.MEM_regwrite, bus.MEM_aluresult);
      end
      rst = 1'b0;
   endtask
`else
   task automatic test_mult();
      set_wb(1'b0, 5'd0, 32'd0);
      apply_stimulus(C_RTYPE, 2'b10, 32'h40, 5'd10, 5'd11, 5'd12, 32'd6, 32'd7, 32'h18, 1'b0);
      #1;
      checks++;
      if (bus.EX_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nomul_stall: got %b want 0", bus.EX_stall);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.MEM_aluresult !== 32'd0 || bus.MEM_regwrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL nomul_result: got %h rw %b want 0 rw 1",
                  bus.MEM_aluresult, bus.MEM_regwrite);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_branch();
      test_flush_reset();
      test_random();
      test_slt();
      test_mult();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
